mux_rr_arbiter_4x1: RTL

Round-robin arbiter and select sequencer for the 4:1 bit multiplexer. Four requesters each own one mux input. The block grants the shared mux output to one requester at a time, drives the 2-bit select, and qualifies the muxed output with a valid flag. It sits between the requesting sources and the downstream single-bit consumer.

---
 rtl/mux_rr_arbiter_4x1.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter_4x1.sv
// mux_rr_arbiter_4x1
// Round-robin arbiter and select sequencer for a shared 4:1 bit multiplexer.
// Four requesters each own one mux input; one of them at a time is granted
// the mux. The block drives a one-hot grant, a binary select and a valid flag.
// The muxed bit is qualified by valid.
//
// Optional feature macro: MUX_RR_ARB_TIMEOUT_EN
//   defined   : tenure counter plus forced rotation after HOLD_MAX cycles
//               when other requests are pending.
//   undefined : an owner keeps the grant as long as its request stays high.
module mux_rr_arbiter_4x1 #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] in,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       out
);

    // The tenure counter is 4 bits wide, so HOLD_MAX must fit in 1..15.
    if ((HOLD_MAX < 1) || (HOLD_MAX > 15)) begin : g_hold_max_range
        $error("HOLD_MAX must be in the range 1..15");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Round-robin search: the order is base+1, base+2, base+3, base.
    // Returns {found, index}. The loop runs from the lowest priority to the
    // highest, so the last hit is the one that is kept.
    function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                           input logic [1:0] base);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = base + k[1:0];
            if (mask[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t     state_r, state_nx_s;
    logic [3:0] gnt_r, gnt_nx_s;
    logic [1:0] sel_r, sel_nx_s;
    logic       valid_r, valid_nx_s;
    logic [1:0] ptr_r, ptr_nx_s;

    logic       arb_en_s;      // arbitrate on this edge
    logic [3:0] arb_mask_s;    // candidates for this arbitration
    logic       keep_empty_s;  // no candidate left: the owner keeps the grant
    logic [2:0] pick_s;        // {found, winner index}

`ifdef MUX_RR_ARB_TIMEOUT_EN
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);
    logic [3:0] cnt_r, cnt_nx_s;
`endif

    // Next-state logic: pick a winner on entry, on a drop, or on a tenure expiry.
    always_comb begin
        state_nx_s   = state_r;
        gnt_nx_s     = gnt_r;
        sel_nx_s     = sel_r;
        valid_nx_s   = valid_r;
        ptr_nx_s     = ptr_r;
        arb_en_s     = 1'b0;
        arb_mask_s   = 4'b0000;
        keep_empty_s = 1'b0;
`ifdef MUX_RR_ARB_TIMEOUT_EN
        cnt_nx_s     = cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                arb_en_s   = 1'b1;
                arb_mask_s = req;
            end
            ST_GRANT: begin
                if (!req[sel_r]) begin
                    // The owner released. A release takes precedence over
                    // forced rotation, and both pick the same winner.
                    arb_en_s   = 1'b1;
                    arb_mask_s = req & ~gnt_r;
                end else begin
`ifdef MUX_RR_ARB_TIMEOUT_EN
                    if (cnt_r == HOLD_LAST) begin
                        arb_en_s     = 1'b1;
                        arb_mask_s   = req & ~gnt_r;
                        keep_empty_s = 1'b1;
                    end else if (cnt_r != 4'hF) begin
                        cnt_nx_s = cnt_r + 4'd1;
                    end else begin
                        cnt_nx_s = cnt_r;
                    end
`else
                    arb_en_s = 1'b0;
`endif
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                gnt_nx_s   = 4'b0000;
                valid_nx_s = 1'b0;
            end
        endcase

        pick_s = rr_pick(arb_mask_s, ptr_r);

        if (arb_en_s) begin
            if (pick_s[2]) begin
                state_nx_s = ST_GRANT;
                gnt_nx_s   = 4'b0001 << pick_s[1:0];
                sel_nx_s   = pick_s[1:0];
                valid_nx_s = 1'b1;
                ptr_nx_s   = pick_s[1:0];
`ifdef MUX_RR_ARB_TIMEOUT_EN
                cnt_nx_s   = 4'd0;
`endif
            end else if (keep_empty_s) begin
`ifdef MUX_RR_ARB_TIMEOUT_EN
                cnt_nx_s   = 4'd0;
`else
                state_nx_s = state_r;
`endif
            end else begin
                // Nobody is requesting: go idle. sel keeps its last value.
                state_nx_s = ST_IDLE;
                gnt_nx_s   = 4'b0000;
                valid_nx_s = 1'b0;
`ifdef MUX_RR_ARB_TIMEOUT_EN
                cnt_nx_s   = 4'd0;
`endif
            end
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // State, grant and pointer registers. Reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            gnt_r   <= 4'b0000;
            sel_r   <= 2'd0;
            valid_r <= 1'b0;
            ptr_r   <= 2'd3;
        end else begin
            state_r <= state_nx_s;
            gnt_r   <= gnt_nx_s;
            sel_r   <= sel_nx_s;
            valid_r <= valid_nx_s;
            ptr_r   <= ptr_nx_s;
        end
    end

`ifdef MUX_RR_ARB_TIMEOUT_EN
    // Tenure counter for the current owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 4'd0;
        end else begin
            cnt_r <= cnt_nx_s;
        end
    end
`endif

    assign gnt   = gnt_r;
    assign sel   = sel_r;
    assign valid = valid_r;

    // Muxed data bit: it follows `in` within the cycle and is gated by valid.
    always_comb begin
        if (valid_r) begin
            out = in[sel_r];
        end else begin
            out = 1'b0;
        end
    end

endmodule
